// File: rtl/count_event_capture.sv
// count_event_capture: watches the registered output of an upstream counter
// and queues the events it observes (entry into the compare value, wrap from
// all-ones to zero, any non-unit step) into a small FIFO, each entry carrying
// a {jump, wrap, match} mask and the count value sampled with it.
// Optional feature: define COUNT_EVENT_DROP_CNT_EN to add drop_cnt_o, a
// saturating count of events lost since the last pop.
module count_event_capture #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] count_i,
  input  logic [DATA_WIDTH-1:0] cmp_val_i,
  input  logic                  cmp_en_i,
  output logic                  evt_valid_o,
  input  logic                  evt_ready_i,
  output logic [2:0]            evt_type_o,
  output logic [DATA_WIDTH-1:0] evt_data_o,
  output logic                  full_o,
  output logic                  drop_o
`ifdef COUNT_EVENT_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt_o
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  // Previous count sample and the priming flag that gates detection
  logic [DATA_WIDTH-1:0] count_q_reg;
  logic                  prime_reg;

  // Detection
  logic [DATA_WIDTH-1:0] count_inc;
  logic                  match_det;
  logic                  wrap_det;
  logic                  jump_det;
  logic [2:0]            evt_mask;
  logic                  evt_det;

  // FIFO state
  logic [2:0]            type_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [AW:0]           occ_reg;
  logic [AW:0]           occ_next;
  logic [DEPTH-1:0]      wr_en;
  logic                  push;
  logic                  pop;
  logic                  drop_det;
  logic                  drop_reg;

  // Sample the counter every cycle; prime goes high one cycle after reset release
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q_reg <= '0;
      prime_reg   <= 1'b0;
    end else begin
      count_q_reg <= count_i;
      prime_reg   <= 1'b1;
    end
  end

  // Classify the step from count_q to count_i; match only on entry to the compare value
  always_comb begin
    count_inc = count_q_reg + DATA_WIDTH'(1);
    match_det = cmp_en_i && (count_i == cmp_val_i) && (count_q_reg != cmp_val_i);
    wrap_det  = (&count_q_reg) && (count_i == '0);
    jump_det  = (count_i != count_q_reg) && (count_i != count_inc) && !wrap_det;
    evt_mask  = {jump_det, wrap_det, match_det};
    evt_det   = prime_reg && (|evt_mask);
  end

  // Handshake and occupancy bookkeeping; a full FIFO still accepts when it pops
  always_comb begin
    evt_valid_o = (occ_reg != '0);
    full_o      = (occ_reg == FULL_CNT);
    pop         = evt_valid_o && evt_ready_i;
    push        = evt_det && (!full_o || pop);
    drop_det    = evt_det && full_o && !pop;
    occ_next    = occ_reg + (AW + 1)'(push) - (AW + 1)'(pop);
    evt_type_o  = evt_valid_o ? type_mem[rd_ptr_reg] : 3'b000;
    evt_data_o  = evt_valid_o ? data_mem[rd_ptr_reg] : '0;
    drop_o      = drop_reg;
  end

  // One write enable per FIFO slot, selected by the write pointer
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_ptr_reg == AW'(gi));
    end
  endgenerate

  // Entry storage; contents need no reset because the outputs are gated by valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        type_mem[i] <= evt_mask;
        data_mem[i] <= count_i;
      end
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; drop is a registered pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
      drop_reg   <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      occ_reg  <= occ_next;
      drop_reg <= drop_det;
    end
  end

`ifdef COUNT_EVENT_DROP_CNT_EN
  logic [7:0] drop_cnt_reg;

  // Lost-event counter: cleared by any pop, otherwise counts drops up to 255
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_reg <= 8'd0;
    end else if (pop) begin
      drop_cnt_reg <= drop_det ? 8'd1 : 8'd0;
    end else if (drop_det && (drop_cnt_reg != 8'hFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign drop_cnt_o = drop_cnt_reg;
`else
  // No drop counter in this build.
`endif

endmodule

// File: tb/tb_count_event_capture.sv
// Directed bench for count_event_capture (DATA_WIDTH=8, DEPTH=4).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_count_event_capture;

  logic       clk;
  logic       rst;
  logic [7:0] count_i;
  logic [7:0] cmp_val_i;
  logic       cmp_en_i;
  logic       evt_valid_o;
  logic       evt_ready_i;
  logic [2:0] evt_type_o;
  logic [7:0] evt_data_o;
  logic       full_o;
  logic       drop_o;
`ifdef COUNT_EVENT_DROP_CNT_EN
  logic [7:0] drop_cnt_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int drop_seen;

  count_event_capture #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .count_i     (count_i),
    .cmp_val_i   (cmp_val_i),
    .cmp_en_i    (cmp_en_i),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_type_o  (evt_type_o),
    .evt_data_o  (evt_data_o),
    .full_o      (full_o),
    .drop_o      (drop_o)
`ifdef COUNT_EVENT_DROP_CNT_EN
    ,
    .drop_cnt_o  (drop_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %s got=%0h exp=%0h ok", tag, got, exp);
    end else begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    count_i     = 8'h00;
    cmp_val_i   = 8'h00;
    cmp_en_i    = 1'b0;
    evt_ready_i = 1'b0;

    // Reset state
    do_reset();
    check("rst_valid", 32'(evt_valid_o), 32'd0);
    check("rst_full",  32'(full_o),      32'd0);
    check("rst_drop",  32'(drop_o),      32'd0);
    check("rst_type",  32'(evt_type_o),  32'd0);
    check("rst_data",  32'(evt_data_o),  32'd0);

    // Wrap: FE, FF, 00
    evt_ready_i = 1'b1;
    count_i = 8'hFE; tick();
    check("wrap_prime_valid", 32'(evt_valid_o), 32'd0);
    count_i = 8'hFF; tick();
    check("wrap_step_valid", 32'(evt_valid_o), 32'd0);
    count_i = 8'h00; tick();
    check("wrap_valid", 32'(evt_valid_o), 32'd1);
    check("wrap_type",  32'(evt_type_o),  32'h2);
    check("wrap_data",  32'(evt_data_o),  32'h00);
    tick();
    check("wrap_single", 32'(evt_valid_o), 32'd0);

    // Match entry edge: 4, 5, 5, 5, 6
    do_reset();
    cmp_en_i = 1'b1; cmp_val_i = 8'h05; evt_ready_i = 1'b1;
    count_i = 8'h04; tick();
    count_i = 8'h05; tick();
    check("match_valid", 32'(evt_valid_o), 32'd1);
    check("match_type",  32'(evt_type_o),  32'h1);
    check("match_data",  32'(evt_data_o),  32'h05);
    tick();
    check("match_hold1", 32'(evt_valid_o), 32'd0);
    tick();
    check("match_hold2", 32'(evt_valid_o), 32'd0);
    count_i = 8'h06; tick();
    check("match_leave", 32'(evt_valid_o), 32'd0);

    // Jump with coincident match: 0x10 -> 0x40
    do_reset();
    cmp_en_i = 1'b1; cmp_val_i = 8'h40; evt_ready_i = 1'b1;
    count_i = 8'h10; tick();
    count_i = 8'h40; tick();
    check("jm_valid", 32'(evt_valid_o), 32'd1);
    check("jm_type",  32'(evt_type_o),  32'h5);
    check("jm_data",  32'(evt_data_o),  32'h40);
    tick();
    check("jm_single", 32'(evt_valid_o), 32'd0);

    // Full and drop: six jumps with the consumer stalled
    do_reset();
    cmp_en_i = 1'b0; evt_ready_i = 1'b0; drop_seen = 0;
    count_i = 8'h00; tick();
    for (int k = 1; k <= 6; k++) begin
      count_i = 8'(k * 16);
      tick();
      drop_seen += int'(drop_o);
      if (k == 1) check("fd_head_stable_type", 32'(evt_type_o), 32'h4);
      if (k == 3) check("fd_not_full", 32'(full_o), 32'd0);
      if (k == 4) check("fd_full", 32'(full_o), 32'd1);
      if (k == 6) check("fd_head_stable_data", 32'(evt_data_o), 32'h10);
    end
    tick();
    drop_seen += int'(drop_o);
    check("fd_drop_total", 32'(drop_seen), 32'd2);
    check("fd_drop_idle",  32'(drop_o),    32'd0);
    check("fd_still_full", 32'(full_o),    32'd1);
`ifdef COUNT_EVENT_DROP_CNT_EN
    check("fd_drop_cnt", 32'(drop_cnt_o), 32'd2);
`endif
    evt_ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("fd_drain%0d_valid", k), 32'(evt_valid_o), 32'd1);
      check($sformatf("fd_drain%0d_type", k),  32'(evt_type_o),  32'h4);
      check($sformatf("fd_drain%0d_data", k),  32'(evt_data_o),  32'(k * 16));
      tick();
    end
    check("fd_empty", 32'(evt_valid_o), 32'd0);
`ifdef COUNT_EVENT_DROP_CNT_EN
    check("fd_drop_cnt_clr", 32'(drop_cnt_o), 32'd0);
`endif

    // Push with pop while full
    do_reset();
    evt_ready_i = 1'b0;
    count_i = 8'h00; tick();
    for (int k = 1; k <= 4; k++) begin
      count_i = 8'(k * 16);
      tick();
    end
    check("pp_full", 32'(full_o), 32'd1);
    evt_ready_i = 1'b1;
    count_i = 8'h70; tick();
    check("pp_full_kept", 32'(full_o), 32'd1);
    check("pp_no_drop",   32'(drop_o), 32'd0);
    tick();
    check("pp_no_drop_late", 32'(drop_o), 32'd0);
    check("pp_head_after", 32'(evt_data_o), 32'h30);
    tick(); tick();
    check("pp_tail_data", 32'(evt_data_o), 32'h70);
    check("pp_tail_type", 32'(evt_type_o), 32'h4);
    tick();
    check("pp_empty", 32'(evt_valid_o), 32'd0);

    // Mid-operation reset with three queued entries
    do_reset();
    evt_ready_i = 1'b0; cmp_en_i = 1'b0;
    count_i = 8'h00; tick();
    for (int k = 1; k <= 3; k++) begin
      count_i = 8'(k * 16);
      tick();
    end
    check("mr_queued", 32'(evt_valid_o), 32'd1);
    rst = 1'b1; cmp_en_i = 1'b1; cmp_val_i = 8'h33; count_i = 8'h33;
    tick();
    check("mr_valid", 32'(evt_valid_o), 32'd0);
    check("mr_full",  32'(full_o),      32'd0);
    check("mr_type",  32'(evt_type_o),  32'd0);
    rst = 1'b0;
    tick();
    check("mr_prime_no_evt", 32'(evt_valid_o), 32'd0);
    tick();
    check("mr_hold_no_evt", 32'(evt_valid_o), 32'd0);
    count_i = 8'h80; tick();
    check("mr_restart_valid", 32'(evt_valid_o), 32'd1);
    check("mr_restart_type",  32'(evt_type_o),  32'h4);
    check("mr_restart_data",  32'(evt_data_o),  32'h80);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/count_event_capture.md
COUNT_EVENT_CAPTURE -- requirements
Module: count_event_capture

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of the sampled count value.
REQ-002 SHALL have parameter DEPTH, default 4, power of two, at least 2: number of event FIFO entries.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port count_i, input, DATA_WIDTH bits: registered count output of the upstream counter, sampled every cycle.
REQ-006 SHALL have port cmp_val_i, input, DATA_WIDTH bits: compare value for match detection.
REQ-007 SHALL have port cmp_en_i, input, 1 bit: enables match detection.
REQ-008 SHALL have port evt_valid_o, output, 1 bit: FIFO head is valid.
REQ-009 SHALL have port evt_ready_i, input, 1 bit: consumer accepts the head entry.
REQ-010 SHALL have port evt_type_o, output, 3 bits: head event mask {jump, wrap, match}.
REQ-011 SHALL have port evt_data_o, output, DATA_WIDTH bits: count_i value captured with the head event.
REQ-012 SHALL have port full_o, output, 1 bit: FIFO holds DEPTH entries.
REQ-013 SHALL have port drop_o, output, 1 bit: one-cycle pulse when a detected event is lost.

Function
REQ-014 SHALL register count_i into count_q every cycle, together with a prime flag that sets one cycle after reset release.
REQ-015 SHALL raise no event while prime is 0, so the first cycle after reset only loads count_q.
REQ-016 SHALL assert match when cmp_en_i=1, count_i==cmp_val_i and count_q!=cmp_val_i.
- This is an entry edge only; holding at the compare value gives one event.
REQ-017 SHALL assert wrap when count_q is all-ones and count_i==0.
REQ-018 SHALL assert jump when count_i!=count_q, count_i!=count_q+1 (modulo 2^DATA_WIDTH) and wrap is 0.
REQ-019 SHALL treat wrap and jump as mutually exclusive; match may coincide with either.
- All asserted bits are stored as one FIFO entry with data=count_i.
REQ-020 SHALL push an entry when any event bit is 1 and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-021 SHALL pop the head when evt_valid_o=1 and evt_ready_i=1.
REQ-022 SHALL present an event sampled in cycle N on evt_valid_o in cycle N+1 when the FIFO was empty (one-cycle latency).
REQ-023 SHALL keep entries in FIFO order and hold evt_type_o/evt_data_o stable while evt_valid_o=1 and evt_ready_i=0.
REQ-024 SHALL pulse drop_o for one cycle when an event is detected, the FIFO is full and no pop occurs; the FIFO is left unchanged.
REQ-025 SHALL wrap read/write pointers modulo DEPTH and derive full_o/empty from an occupancy count of width clog2(DEPTH)+1.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, set the following to 0:
- count_q, prime, pointers, occupancy
- evt_valid_o, full_o, drop_o
- evt_type_o, evt_data_o
REQ-027 SHALL discard all queued entries and any in-flight detection when rst is asserted mid-operation.
- Detection restarts with the priming cycle of REQ-015.

Configuration
REQ-028 SHALL, when macro COUNT_EVENT_DROP_CNT_EN is defined, add output drop_cnt_o (8 bits).
- Increments on each drop_o pulse, saturates at 255.
- Reset to 0.
- Clears to 0 in the cycle after any pop, unless a drop occurs in that cycle, which sets it to 1.
REQ-029 SHALL, when COUNT_EVENT_DROP_CNT_EN is undefined, omit drop_cnt_o and its logic entirely; all other behaviour is unchanged.

Verification
REQ-030 SHALL check wrap detection (DATA_WIDTH=8): count_i steps 0xFE, 0xFF, 0x00 with evt_ready_i=1 -> exactly one entry {type=3'b010, data=0x00}, evt_valid_o high one cycle after the 0x00 sample.
REQ-031 SHALL check match edge: cmp_en_i=1, cmp_val_i=0x05, count_i goes 4, 5, 5, 5, 6 -> exactly one entry {3'b001, 0x05}.
REQ-032 SHALL check jump with coincident match: count_i goes 0x10 then 0x40 with cmp_val_i=0x40 -> one entry {3'b101, 0x40}.
REQ-033 SHALL check full and drop (DEPTH=4): evt_ready_i=0, six jump events ->
- full_o=1 after the fourth event
- drop_o pulses twice
- drop_cnt_o=2 when the macro is defined
- draining yields the first four events in order
REQ-034 SHALL check push with pop when full: FIFO full, event coincides with evt_ready_i=1 -> no drop, full_o stays 1, new entry lands at the tail.
REQ-035 SHALL check mid-operation reset: rst=1 for one cycle with three entries queued ->
- next cycle evt_valid_o=0, full_o=0
- the first post-reset count_i sample produces no event even if it equals cmp_val_i
